// File: rtl/mips_pkg.sv
// Types and constants shared by the fetch stage, the decoder and the bench.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } fetch_state_e;

  localparam logic [1:0]  HC_NONE       = 2'b00;
  localparam logic [1:0]  HC_HALTWORD   = 2'b01;
  localparam logic [1:0]  HC_RANGE      = 2'b10;

  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;
  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

  // Out-of-range fetch outranks a halt word fetched from a valid address.
  function automatic logic [1:0] halt_cause_f(input logic out_of_range,
                                              input logic halt_word);
    logic [1:0] cause;
    if (out_of_range) begin
      cause = HC_RANGE;
    end else if (halt_word) begin
      cause = HC_HALTWORD;
    end else begin
      cause = HC_NONE;
    end
    return cause;
  endfunction

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > fall-through.
module next_pc_calc #(
  parameter int WL_addr = 32
) (
  input  logic [WL_addr-1:0] pc_plus4,
  input  logic               jr,
  input  logic [WL_addr-1:0] jr_addr,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  output logic [WL_addr-1:0] next_pc
);

  logic [WL_addr-1:0] branch_off_s;

  // Priority mux over the redirect sources; branch offset is a sign-extended word count.
  always_comb begin
    branch_off_s = {{(WL_addr-18){branch_imm[15]}}, branch_imm, 2'b00};
    if (jr) begin
      next_pc = {jr_addr[WL_addr-1:2], 2'b00};
    end else if (jump) begin
      next_pc = {pc_plus4[WL_addr-1:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc = pc_plus4 + branch_off_s;
    end else begin
      next_pc = pc_plus4;
    end
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch control: boot/run/halt sequencing, halt detection,
// redirect handling and a saturating retired-instruction counter.
module pc_fetch_unit
  import mips_pkg::*;
#(
  parameter int             WL_addr    = 32,
  parameter int             WL_data    = 32,
  parameter int             IMEM_DEPTH = 32,
  parameter logic [31:0]    RESET_PC   = RESET_PC_DEF,
  parameter logic [31:0]    HALT_WORD  = HALT_WORD_DEF,
  parameter int             CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [15:0]        branch_imm,
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               jr,
  input  logic [WL_addr-1:0] jr_addr,
  input  logic [WL_data-1:0] instr_data,
  output logic [WL_addr-1:0] instr_addr,
  output logic [WL_addr-1:0] pc,
  output logic [WL_addr-1:0] pc_plus4,
  output logic [WL_data-1:0] instr,
  output logic               instr_valid,
  output logic               halted,
  output logic [1:0]         halt_cause,
  output logic [CNT_W-1:0]   instr_count
);

  localparam logic [WL_addr-1:0] DEPTH_W = WL_addr'(IMEM_DEPTH);

  fetch_state_e       state_q, state_d;
  logic [WL_addr-1:0] pc_q, pc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [1:0]         cause_q, cause_d;
  logic               halted_q, halted_d;

  logic [WL_addr-1:0] pc_plus4_s;
  logic [WL_addr-1:0] next_pc_s;
  logic               out_of_range_s;
  logic               halt_word_s;
  logic               instr_valid_s;

  assign instr_addr     = {2'b00, pc_q[WL_addr-1:2]};
  assign pc_plus4_s     = pc_q + WL_addr'(4);
  assign out_of_range_s = (instr_addr >= DEPTH_W);
  assign halt_word_s    = (instr_data == WL_data'(HALT_WORD));

  next_pc_calc #(.WL_addr(WL_addr)) u_next_pc (
    .pc_plus4     (pc_plus4_s),
    .jr           (jr),
    .jr_addr      (jr_addr),
    .jump         (jump),
    .jump_index   (jump_index),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .next_pc      (next_pc_s)
  );

  // Sequencing: halt conditions are checked before stall so a halt word never retires.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    count_d       = count_q;
    cause_d       = cause_q;
    halted_d      = halted_q;
    instr_valid_s = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (out_of_range_s || halt_word_s) begin
          state_d  = ST_HALT;
          cause_d  = halt_cause_f(out_of_range_s, halt_word_s);
          halted_d = 1'b1;
        end else if (!stall) begin
          instr_valid_s = 1'b1;
          pc_d          = next_pc_s;
          count_d       = (&count_q) ? count_q : count_q + CNT_W'(1);
        end else begin
          instr_valid_s = 1'b1;
        end
      end
      ST_HALT: begin
        halted_d = 1'b1;
      end
      default: begin
        state_d  = ST_HALT;
        halted_d = 1'b1;
      end
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_BOOT;
      pc_q     <= WL_addr'(RESET_PC);
      count_q  <= '0;
      cause_q  <= HC_NONE;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      count_q  <= count_d;
      cause_q  <= cause_d;
      halted_q <= halted_d;
    end
  end

  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_s;
  assign instr_valid = instr_valid_s;
  assign instr       = instr_valid_s ? instr_data : '0;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand sequences, then random
// stimulus checked against a behavioural model of the fetch rules.
module tb_pc_fetch_unit;
  import mips_pkg::*;

  localparam int DEPTH   = 8;
  localparam int CW      = 8;
  localparam int CNT_MAX = 255;

  logic        clk = 1'b0;
  logic        rst, stall, branch_taken, jump, jr;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_addr, instr_data, instr_addr, pc, pc_plus4, instr;
  logic        instr_valid, halted;
  logic [1:0]  halt_cause;
  logic [CW-1:0] instr_count;

  logic [31:0] mem [0:63];

  int pass_cnt = 0;
  int total_cnt = 0;

  // behavioural model state
  bit          m_known = 1'b0;
  bit          m_booting, m_stopped;
  logic [31:0] m_pc;
  int          m_cnt;
  logic [1:0]  m_cause;

  always #5 clk = ~clk;

  assign instr_data = (instr_addr < 32'd64) ? mem[instr_addr[5:0]] : 32'h0BAD_0000;

  pc_fetch_unit #(.IMEM_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_imm(branch_imm), .jump(jump), .jump_index(jump_index), .jr(jr),
    .jr_addr(jr_addr), .instr_data(instr_data), .instr_addr(instr_addr),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .instr_valid(instr_valid),
    .halted(halted), .halt_cause(halt_cause), .instr_count(instr_count)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
  endtask

  task automatic drive(input logic r, input logic s, input logic b, input logic [15:0] imm,
                       input logic j, input logic [25:0] ji, input logic jrr, input logic [31:0] ja);
    rst = r; stall = s; branch_taken = b; branch_imm = imm;
    jump = j; jump_index = ji; jr = jrr; jr_addr = ja;
  endtask

  function automatic logic [31:0] target();
    logic [31:0] p4;
    int off;
    p4 = m_pc + 32'd4;
    off = $signed(branch_imm);
    if (jr) return jr_addr & ~32'd3;
    else if (jump) return {p4[31:28], jump_index, 2'b00};
    else if (branch_taken) return p4 + 32'(off * 4);
    else return p4;
  endfunction

  task automatic model_compare();
    logic [31:0] idx;
    bit run, oor, hw, ev;
    if (!m_known) return;
    idx = m_pc >> 2;
    run = !m_booting && !m_stopped;
    oor = idx >= DEPTH;
    hw  = !oor && (mem[idx[5:0]] == 32'hFFFF_FFFF);
    ev  = run && !oor && !hw;
    chk("m_instr_addr", instr_addr, idx);
    chk("m_pc", pc, m_pc);
    chk("m_pc_plus4", pc_plus4, m_pc + 32'd4);
    chk("m_instr_valid", {31'd0, instr_valid}, {31'd0, ev});
    chk("m_instr", instr, ev ? mem[idx[5:0]] : 32'd0);
    chk("m_halted", {31'd0, halted}, {31'd0, m_stopped});
    chk("m_halt_cause", {30'd0, halt_cause}, {30'd0, m_cause});
    chk("m_instr_count", {24'd0, instr_count}, 32'(m_cnt));
  endtask

  task automatic model_update();
    logic [31:0] idx;
    idx = m_pc >> 2;
    if (rst) begin
      m_known = 1'b1; m_pc = 32'd0; m_booting = 1'b1; m_stopped = 1'b0;
      m_cnt = 0; m_cause = 2'b00;
    end else if (!m_known || m_stopped) begin
      m_cnt = m_cnt;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (idx >= DEPTH) begin
      m_stopped = 1'b1; m_cause = 2'b10;
    end else if (mem[idx[5:0]] == 32'hFFFF_FFFF) begin
      m_stopped = 1'b1; m_cause = 2'b01;
    end else if (!stall) begin
      m_pc = target();
      if (m_cnt < CNT_MAX) m_cnt++;
    end
  endtask

  task automatic cycle();
    #1;
    model_compare();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  typedef struct {
    logic r, s, b; logic [15:0] imm; logic j; logic [25:0] ji; logic jrr; logic [31:0] ja;
    bit chk_en; logic [31:0] e_addr; logic e_valid; int e_cnt; logic e_halted; logic [1:0] e_cause;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic s, logic b, logic [15:0] imm, logic j,
                              logic [25:0] ji, logic jrr, logic [31:0] ja, bit c,
                              logic [31:0] ea, logic ev, int ec, logic eh, logic [1:0] ecs);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.imm = imm; v.j = j; v.ji = ji; v.jrr = jrr; v.ja = ja;
    v.chk_en = c; v.e_addr = ea; v.e_valid = ev; v.e_cnt = ec; v.e_halted = eh; v.e_cause = ecs;
    return v;
  endfunction

  initial begin
    vec_t v;
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 + 32'(i);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);

    // free run, branches back/forward, range halt
    vq.push_back(mk(1,0,0,16'h0000,0,26'd0,0,32'd0, 0, 32'd0,0,0,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd0,0,0,0,2'd0));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'(k),1,k,0,2'd0));
    vq.push_back(mk(0,0,1,16'hFFFE,0,26'd0,0,32'd0, 1, 32'd4,1,4,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd3,1,5,0,2'd0));
    vq.push_back(mk(0,0,1,16'h0003,0,26'd0,0,32'd0, 1, 32'd4,1,6,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,7,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,7,1,2'd2));
    // reset out of HALT, redirect priority, stall
    vq.push_back(mk(1,0,0,16'h0000,1,26'd3,0,32'd0, 1, 32'd8,0,7,1,2'd2));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,1,32'h10, 1, 32'd0,0,0,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd0,1,0,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd1,1,1,0,2'd0));
    vq.push_back(mk(0,0,1,16'h0003,1,26'd5,0,32'd0, 1, 32'd2,1,2,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,1,32'h08, 1, 32'd5,1,3,0,2'd0));
    vq.push_back(mk(0,0,1,16'h0003,1,26'd5,1,32'h1F, 1, 32'd2,1,4,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,1,32'h04, 1, 32'd7,1,5,0,2'd0));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(0,1,0,16'h0000,1,26'd2,0,32'd0, 1, 32'd1,1,6,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,1,26'd2,0,32'd0, 1, 32'd1,1,6,0,2'd0));
    for (int k = 2; k < 8; k++)
      vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'(k),1,k+5,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,13,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,13,1,2'd2));
    // straight line to the end of an 8-word memory
    vq.push_back(mk(1,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,13,1,2'd2));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd0,0,0,0,2'd0));
    for (int k = 0; k < 8; k++)
      vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'(k),1,k,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,8,0,2'd0));
    vq.push_back(mk(0,0,0,16'h0000,0,26'd0,0,32'd0, 1, 32'd8,0,8,1,2'd2));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      drive(v.r, v.s, v.b, v.imm, v.j, v.ji, v.jrr, v.ja);
      if (v.chk_en) begin
        #1;
        chk("t_instr_addr", instr_addr, v.e_addr);
        chk("t_instr_valid", {31'd0, instr_valid}, {31'd0, v.e_valid});
        chk("t_instr_count", {24'd0, instr_count}, 32'(v.e_cnt));
        chk("t_halted", {31'd0, halted}, {31'd0, v.e_halted});
        chk("t_halt_cause", {30'd0, halt_cause}, {30'd0, v.e_cause});
      end
      cycle();
    end

    // halt word at word 6, frozen PC, reset release
    mem[6] = 32'hFFFF_FFFF;
    drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    cycle();
    drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    repeat (7) cycle();
    #1;
    chk("hw_pc", pc, 32'h18);
    chk("hw_valid", {31'd0, instr_valid}, 32'd0);
    chk("hw_instr", instr, 32'd0);
    cycle();
    #1;
    chk("hw_halted", {31'd0, halted}, 32'd1);
    chk("hw_cause", {30'd0, halt_cause}, {30'd0, HC_HALTWORD});
    drive(1'b0, 1'b0, 1'b1, 16'h0004, 1'b1, 26'd1, 1'b1, 32'h4);
    cycle();
    #1;
    chk("hw_pc_frozen", pc, 32'h18);
    drive(1'b1, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b0, 32'd0);
    cycle();
    #1;
    chk("hw_rst_pc", pc, 32'd0);
    chk("hw_rst_halted", {31'd0, halted}, 32'd0);
    mem[6] = 32'h2000_0006;

    // counter saturation: jr to 0 every cycle
    drive(1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 26'd0, 1'b1, 32'd0);
    repeat (270) cycle();
    #1;
    chk("sat_count", {24'd0, instr_count}, 32'd255);

    // random stimulus against the model
    for (int n = 0; n < 2500; n++) begin
      logic r;
      r = ($urandom_range(0, 39) == 0) || (m_stopped && ($urandom_range(0, 3) == 0));
      if (r) begin
        for (int i = 0; i < 64; i++)
          mem[i] = ($urandom_range(0, 11) == 0) ? 32'hFFFF_FFFF : $urandom;
      end
      drive(r, $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
            16'($urandom_range(0, 15)) - 16'd8, $urandom_range(0, 5) == 0,
            26'($urandom_range(0, 9)), $urandom_range(0, 7) == 0,
            ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 40)));
      cycle();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
